uart_frame_sender: RTL and testbench
====================================

UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameter CLK_DIV, default 100000, clock cycles per UART bit time (legal range 2 and up).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal range 5..8).
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-004 Parameter FIFO_DEPTH, default 4, byte buffer depth (power of two, 2..16).
REQ-005 Parameter PARITY_ODD, default 0, parity sense (1 = odd, 0 = even); used only with UART_PARITY_EN.
REQ-006 Port clk, input, 1, single system clock; all logic on rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port in_data, input, 8, byte to send; bits above DATA_BITS-1 ignored.
REQ-009 Port in_valid, input, 1, in_data offered this cycle.
REQ-010 Port in_ready, output, 1, FIFO can accept a byte (not full).
REQ-011 Port dout, output, 1, serial line, idle high.
REQ-012 Port busy, output, 1, serializer not in IDLE.
REQ-013 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, bytes currently buffered.

Function
REQ-014 Push occurs on a cycle with in_valid && in_ready; in_ready is combinationally !full; in_valid while full is dropped with no side effect.
REQ-015 Serializer states: IDLE, START, DATA, PARITY, STOP; FSM encoding via shared package enum.
REQ-016 IDLE: dout=1; when FIFO non-empty, pop head into shift register, clear baud counter, go to START next cycle.
REQ-017 Latency: byte pushed into empty FIFO at edge N drives dout low starting at edge N+2.
REQ-018 Baud counter counts 0..CLK_DIV-1; each bit held exactly CLK_DIV cycles; state/bit advance when counter = CLK_DIV-1.
REQ-019 START: dout=0 one bit time; DATA: DATA_BITS bits LSB first; STOP: dout=1 for STOP_BITS bit times, then IDLE.
REQ-020 Frame duration (START entry to IDLE re-entry) = (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, P = 1 with parity else 0.
REQ-021 Back-to-back: if FIFO non-empty on return to IDLE, next START begins after exactly one IDLE cycle.
REQ-022 Simultaneous push and pop: fifo_count unchanged, both take effect; pop when empty never occurs.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; full when fifo_count = FIFO_DEPTH, empty when 0.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 rst asserted at an edge: state=IDLE, dout=1, busy=0, FIFO emptied (fifo_count=0, in_ready=1), baud counter=0.
REQ-026 rst mid-frame aborts frame; dout high from the following cycle; aborted and buffered bytes are discarded.

Configuration
REQ-027 Macro UART_PARITY_EN defined: PARITY state inserted after DATA, one bit time, bit = XOR of data bits XOR PARITY_ODD.
REQ-028 UART_PARITY_EN undefined: no PARITY state, DATA goes directly to STOP, PARITY_ODD unused.

Structure
REQ-029 Package uart_pkg holds: FSM state enum, IDLE line level constant, parameter legal-range limits.
REQ-030 One sub-module uart_tx_fifo (synchronous FIFO, push/pop/count/full/empty); baud counter and FSM in top.

Verification (CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless noted)
REQ-031 Push 0x55 at edge N -> dout low edges N+2..N+5, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; busy high 40 cycles.
REQ-032 Push 6 bytes consecutively from reset -> first popped, in_ready low after 5th accepted, 6th dropped; 5 frames each separated by one idle cycle.
REQ-033 UART_PARITY_EN, PARITY_ODD=0, push 0x07 -> parity bit 1 after bit 7, frame 44 cycles; PARITY_ODD=1 -> parity 0.
REQ-034 DATA_BITS=7, STOP_BITS=2, push 0xFF -> start 0, seven 1s, two stop bits, frame 40 cycles, bit 7 not sent.
REQ-035 Push 3 bytes, assert rst during 2nd data bit -> dout=1, busy=0, fifo_count=0 next cycle; no further frames.
REQ-036 Push on same cycle serializer pops from 1-entry FIFO -> fifo_count stays 1, byte order preserved on dout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame sender.
// Holds the serializer state encoding, the idle line level and the legal
// parameter ranges checked at elaboration by uart_frame_sender.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;

  localparam int unsigned CLK_DIV_MIN    = 2;
  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 8;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;
  localparam int unsigned FIFO_DEPTH_MIN = 2;
  localparam int unsigned FIFO_DEPTH_MAX = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serializer.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, wdata       - write request (ignored when full) and data
//   pop               - read request (ignored when empty)
//   head_c            - current head entry (show-ahead, read before pop)
//   count             - number of stored entries
//   full, empty       - registered occupancy flags
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Occupancy next value; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_frame_sender.sv
// Buffered UART transmitter: bytes are queued in a small FIFO and sent as
// start / DATA_BITS data (LSB first) / [parity] / STOP_BITS stop frames.
// Optional parity bit is enabled by defining the macro UART_PARITY_EN.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   in_data     - byte to send (bits above DATA_BITS-1 ignored)
//   in_valid    - in_data offered this cycle
//   in_ready    - FIFO not full (push happens on in_valid && in_ready)
//   dout        - serial line, idle high
//   busy        - serializer is sending a frame
//   fifo_count  - bytes currently buffered
module uart_frame_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  // Reject illegal configurations at elaboration.
  if (CLK_DIV < CLK_DIV_MIN ||
      DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD > 1) begin : g_bad_param
    $error("uart_frame_sender: parameter out of legal range");
  end

  uart_state_t       state;
  uart_state_t       state_d;
  logic [CNT_W-1:0]  baud_cnt;
  logic [CNT_W-1:0]  baud_cnt_d;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_d;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_reg_d;
  logic              dout_d;
  logic              busy_d;
  logic              bit_end_c;
  logic              push_c;
  logic              pop_c;
  logic              full;
  logic              empty;
  logic [7:0]        head_c;

`ifdef UART_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  logic parity_bit;
  logic parity_bit_d;
`endif

  assign in_ready  = !full;
  assign push_c    = in_valid && !full;
  assign bit_end_c = (baud_cnt == CNT_W'(CLK_DIV - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (in_data),
    .head_c (head_c),
    .count  (fifo_count),
    .full   (full),
    .empty  (empty)
  );

  // Serializer next state. dout/busy are registered from the current
  // state, so the line follows the state by one cycle.
  always_comb begin
    state_d     = state;
    baud_cnt_d  = baud_cnt;
    bit_idx_d   = bit_idx;
    shift_reg_d = shift_reg;
    pop_c       = 1'b0;
    dout_d      = LINE_IDLE;
    busy_d      = 1'b1;
`ifdef UART_PARITY_EN
    parity_bit_d = parity_bit;
`endif

    if (state != ST_IDLE) begin
      baud_cnt_d = bit_end_c ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!empty) begin
          pop_c       = 1'b1;
          shift_reg_d = head_c;
          baud_cnt_d  = '0;
          bit_idx_d   = '0;
          state_d     = ST_START;
`ifdef UART_PARITY_EN
          parity_bit_d = (^(head_c & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
        end
      end
      ST_START: begin
        dout_d = 1'b0;
        if (bit_end_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        dout_d = shift_reg[0];
        if (bit_end_c) begin
          shift_reg_d = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UART_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        dout_d = parity_bit;
        if (bit_end_c) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        dout_d = 1'b1;
        if (bit_end_c) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      dout      <= LINE_IDLE;
      busy      <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_idx   <= bit_idx_d;
      shift_reg <= shift_reg_d;
      dout      <= dout_d;
      busy      <= busy_d;
`ifdef UART_PARITY_EN
      parity_bit <= parity_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Self-checking bench for uart_frame_sender (CLK_DIV=4, FIFO_DEPTH=4).
// A queue-based line model predicts dout/busy/fifo_count/in_ready every
// cycle for the 8N1 instance; a table of directed frames plus hand-written
// sequences cover latency, burst/full, reset abort and push-on-pop.
// A second instance (DATA_BITS=7, STOP_BITS=2, PARITY_ODD=1) covers the
// narrow-word / two-stop configuration. Honours UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_frame_sender;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       dout;
  logic       busy;
  logic [2:0] fifo_count;

  logic [7:0] in_data_b = 8'h00;
  logic       in_valid_b = 1'b0;
  logic       in_ready_b;
  logic       dout_b;
  logic       busy_b;
  logic [2:0] fifo_count_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int rises  = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_frame_sender #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .busy(busy), .fifo_count(fifo_count)
  );

  uart_frame_sender #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .dout(dout_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (8N1 instance) ----------------
  logic [7:0] fifo_m[$];
  logic       line_m[$];
  logic       exp_dout = 1'b1;
  logic       exp_busy = 1'b0;

  // Expand one byte into the per-cycle line levels of its frame.
  task automatic build_frame(input logic [7:0] b);
    logic par;
    par = 1'b0;
    for (int r = 0; r < CLK_DIV; r++) line_m.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      par = par ^ b[i];
      for (int r = 0; r < CLK_DIV; r++) line_m.push_back(b[i]);
    end
    if (P == 1) begin
      for (int r = 0; r < CLK_DIV; r++) line_m.push_back(par);
    end
    for (int r = 0; r < CLK_DIV; r++) line_m.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    logic [7:0] b;
    logic was_idle;
    logic do_push;
    if (rst) begin
      fifo_m.delete();
      line_m.delete();
      exp_dout = 1'b1;
      exp_busy = 1'b0;
    end else begin
      was_idle = (line_m.size() == 0);
      do_push  = in_valid && (fifo_m.size() < FIFO_DEPTH);
      if (!was_idle) begin
        exp_dout = line_m.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_dout = 1'b1;
        exp_busy = 1'b0;
      end
      if (was_idle && fifo_m.size() > 0) begin
        b = fifo_m.pop_front();
        build_frame(b);
      end
      if (do_push) fifo_m.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("line_dout", dout, exp_dout);
      chk("line_busy", busy, exp_busy);
      chk("line_fifo_count", fifo_count, fifo_m.size());
      chk("line_in_ready", in_ready, (fifo_m.size() < FIFO_DEPTH) ? 1 : 0);
    end
  end

  // Frame counter for the main instance.
  always @(negedge clk) begin
    if (busy && !busy_prev) rises++;
    busy_prev = busy;
  end

  // ---------------- helpers ----------------
  function automatic logic dout_of(input int which);
    return (which == 0) ? dout : dout_b;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy : busy_b;
  endfunction

  task automatic drive(input int which, input logic [7:0] d, input logic v);
    if (which == 0) begin
      in_data = d; in_valid = v;
    end else begin
      in_data_b = d; in_valid_b = v;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          which;
    logic [7:0]  data;
    logic [11:0] frame;  // bit k = k-th bit on the line (start first)
    int          nbits;
  } vec_t;

  // Push one byte from idle, sample every bit mid-way, check busy window.
  task automatic run_vec(input int idx, input vec_t v);
    logic [11:0] got;
    got = '0;
    @(negedge clk); drive(v.which, v.data, 1'b1);
    @(negedge clk); drive(v.which, 8'h00, 1'b0);
    @(negedge clk);
    chk($sformatf("vec%0d_busy_pre", idx), busy_of(v.which), 0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < v.nbits; k++) begin
      if (k > 0) repeat (CLK_DIV) @(negedge clk);
      got[k] = dout_of(v.which);
    end
    chk($sformatf("vec%0d_frame", idx), got, v.frame);
    @(negedge clk);
    chk($sformatf("vec%0d_busy_last", idx), busy_of(v.which), 1);
    @(negedge clk);
    chk($sformatf("vec%0d_busy_end", idx), busy_of(v.which), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[7];
    logic [7:0] three[3];
    three[0] = 8'hC3; three[1] = 8'h3C; three[2] = 8'h5A;

`ifdef UART_PARITY_EN
    vecs[0] = '{0, 8'h55, 12'h4AA, 11};
    vecs[1] = '{0, 8'h07, 12'h60E, 11};
    vecs[2] = '{0, 8'h00, 12'h400, 11};
    vecs[3] = '{0, 8'hFF, 12'h5FE, 11};
    vecs[4] = '{0, 8'hA3, 12'h546, 11};
    vecs[5] = '{1, 8'hFF, 12'h6FE, 11};
    vecs[6] = '{1, 8'h80, 12'h700, 11};
`else
    vecs[0] = '{0, 8'h55, 12'h2AA, 10};
    vecs[1] = '{0, 8'h07, 12'h20E, 10};
    vecs[2] = '{0, 8'h00, 12'h200, 10};
    vecs[3] = '{0, 8'hFF, 12'h3FE, 10};
    vecs[4] = '{0, 8'hA3, 12'h346, 10};
    vecs[5] = '{1, 8'hFF, 12'h3FE, 10};
    vecs[6] = '{1, 8'h80, 12'h300, 10};
`endif

    // Reset state.
    do_reset();
    chk("rst_dout", dout, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_dout", dout_b, 1);
    chk("rst_b_fifo_count", fifo_count_b, 0);
    chk_en = 1'b1;

    // Directed single frames.
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Burst of six pushes: fifth fills the FIFO, sixth is dropped.
    do_reset();
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); in_data = 8'(8'h10 + i); in_valid = 1'b1;
    end
    @(negedge clk);
    chk("burst_fifo_count", fifo_count, 4);
    chk("burst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (5 * 41 + 20) @(negedge clk);
    chk("burst_frames", rises, 5);

    // Reset during the second data bit aborts everything.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_data = three[i]; in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_dout", dout, 1);
    chk("abort_busy", busy, 0);
    chk("abort_fifo_count", fifo_count, 0);
    rises = 0;
    repeat (100) @(negedge clk);
    chk("abort_no_frames", rises, 0);

    // Push on the same edge the serializer pops a one-entry FIFO.
    do_reset();
    @(negedge clk); in_data = 8'h3C; in_valid = 1'b1;
    @(negedge clk); in_data = 8'hC5;
    @(negedge clk); in_valid = 1'b0;
    chk("pushpop_fifo_count", fifo_count, 1);
    repeat (100) @(negedge clk);
    chk("pushpop_idle_count", fifo_count, 0);

    // Random traffic with occasional resets, checked by the line model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, (c < 1500) ? 7 : 47) == 0);
      in_data  = 8'($urandom);
      rst      = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    repeat (250) @(negedge clk);
    chk("drain_fifo_count", fifo_count, 0);
    chk("drain_busy", busy, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
